// File: rtl/gcd_arbiter_if.sv
// rtl/gcd_arbiter_if.sv - signal bundle between requesters, gcd_arbiter and the shared gcd unit
//
// Purpose: groups the per-requester request/response channels, the gcd
// unit req/ack channel and the status outputs of gcd_arbiter.
// Ports (signals):
//   req_valid/req_ready/req_a/req_b  requester operand channels (packed per requester)
//   rsp_valid/rsp_ready/rsp_data     per-requester result channel, shared data bus
//   gcd_req/gcd_ab/gcd_ack/gcd_c     four-phase link to the gcd unit
//   busy/grant_id                    status
// Modports: master = arbiter side, slave = environment side.
interface gcd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic                     gcd_req;
  logic [WIDTH-1:0]         gcd_ab;
  logic                     gcd_ack;
  logic [WIDTH-1:0]         gcd_c;
  logic                     busy;
  logic [IDW-1:0]           grant_id;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready, gcd_ack, gcd_c,
    output req_ready, rsp_valid, rsp_data, gcd_req, gcd_ab, busy, grant_id
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ready, gcd_ack, gcd_c,
    input  req_ready, rsp_valid, rsp_data, gcd_req, gcd_ab, busy, grant_id
  );
endinterface

// File: rtl/gcd_arbiter.sv
// rtl/gcd_arbiter.sv - round-robin arbiter sharing one gcd unit between NUM_REQ requesters
//
// Purpose: grants one requester at a time, drives the gcd unit through its
// A phase and B phase four-phase handshakes, and returns the result on the
// granted requester's response channel. Zero operands bypass the gcd unit.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      gcd_arbiter_if.master: requester, response, gcd-unit and status signals
module gcd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input logic           clk,
  input logic           reset_n,
  gcd_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, A_REQ, A_REL, B_REQ, B_REL, RESP} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   gcd_ab_q, gcd_ab_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               gcd_req_q, gcd_req_d;
  logic               busy_q, busy_d;
  // Arbitration works on a registered copy of req_valid so req_ready never
  // depends combinationally on an input. Requesters hold req_valid until
  // accepted, so the copy never offers a grant to a withdrawn request.
  logic [NUM_REQ-1:0] req_valid_q;

  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [IDW-1:0]     cand;
  logic [NUM_REQ-1:0] req_ready_dec;
  logic [NUM_REQ-1:0] rsp_valid_dec;

  // Round-robin search starting just after the last grant, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid_q[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          a_d        = bus.req_a[int'(win_idx)*WIDTH +: WIDTH];
          b_d        = bus.req_b[int'(win_idx)*WIDTH +: WIDTH];
          grant_id_d = win_idx;
          ptr_d      = win_idx;
          // The gcd unit's subtract loop never terminates on a zero operand.
          if (a_d == '0 || b_d == '0) begin
            result_d = a_d | b_d;
            state_d  = RESP;
          end else begin
            state_d  = A_REQ;
          end
        end
      end
      A_REQ: if (bus.gcd_ack) state_d = A_REL;
      A_REL: if (!bus.gcd_ack) state_d = B_REQ;
      B_REQ: begin
        if (bus.gcd_ack) begin
          result_d = bus.gcd_c;
          state_d  = B_REL;
        end
      end
      B_REL: if (!bus.gcd_ack) state_d = RESP;
      RESP:  if (bus.rsp_ready[grant_id_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    gcd_req_d = (state_d == A_REQ) || (state_d == B_REQ);
    busy_d    = (state_d != IDLE);
    case (state_d)
      A_REQ, A_REL: gcd_ab_d = a_d;
      B_REQ, B_REL: gcd_ab_d = b_d;
      default:      gcd_ab_d = gcd_ab_q;
    endcase
  end

  always_comb begin
    req_ready_dec = '0;
    rsp_valid_dec = '0;
    if (state_q == IDLE && win_found) req_ready_dec[win_idx] = 1'b1;
    if (state_q == RESP) rsp_valid_dec[grant_id_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      gcd_ab_q    <= '0;
      grant_id_q  <= '0;
      ptr_q       <= IDW'(NUM_REQ - 1);
      gcd_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      req_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      gcd_ab_q    <= gcd_ab_d;
      grant_id_q  <= grant_id_d;
      ptr_q       <= ptr_d;
      gcd_req_q   <= gcd_req_d;
      busy_q      <= busy_d;
      req_valid_q <= bus.req_valid;
    end
  end

  assign bus.req_ready = req_ready_dec;
  assign bus.rsp_valid = rsp_valid_dec;
  assign bus.rsp_data  = result_q;
  assign bus.gcd_req   = gcd_req_q;
  assign bus.gcd_ab    = gcd_ab_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_id_q;

endmodule
